// File: rtl/vga_scanout.sv
// vga_scanout -- raster timing generator and registered pixel output stage.
//
// Walks an x/y scan position across the full raster (active + porches + sync)
// one step per pix_en strobe. Renderers use x/y/video_on to produce a merged
// colour on rgb_in, which is blanked outside the active area and registered
// together with hsync/vsync, so all three DAC signals share one pixel of
// latency. frame_tick pulses once per frame on entry to vertical blanking.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   pix_en       pixel strobe; nothing advances while low
//   rgb_in       12-bit colour for the current x/y (combinational from renderers)
//   x, y         current scan position
//   video_on     x/y lie inside the visible area (combinational)
//   vga_rgb      registered colour {R,G,B}, zero while blanked
//   hsync, vsync registered sync outputs, polarity set by HS_POL/VS_POL
//   frame_tick   one-clk pulse when scan enters line V_ACTIVE
module vga_scanout #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [11:0] rgb_in,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic [11:0] vga_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE - 1);

    logic line_end;
    logic frame_end;
    logic hs_act;
    logic vs_act;
    logic tick_pos;

    always_comb begin
        video_on  = (x < H_ACT) && (y < V_ACT);
        line_end  = (x == H_LAST);
        frame_end = line_end && (y == V_LAST);
        hs_act    = (x >= HS_BEG) && (x < HS_END);
        vs_act    = (y >= VS_BEG) && (y < VS_END);
        // Last pixel of the last visible line: the next step enters blanking.
        tick_pos  = line_end && (y == V_ACT_L);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            vga_rgb    <= '0;
            hsync      <= !HS_POL;
            vsync      <= !VS_POL;
            frame_tick <= 1'b0;
        end else begin
            // Pulse is one clk wide even when pix_en stays high or low.
            frame_tick <= 1'b0;
            if (pix_en) begin
                // Outputs come from the pre-increment position so colour
                // and sync stay aligned after the one-pixel register.
                vga_rgb    <= video_on ? rgb_in : 12'h000;
                hsync      <= hs_act ? HS_POL : !HS_POL;
                vsync      <= vs_act ? VS_POL : !VS_POL;
                frame_tick <= tick_pos;
                if (frame_end) begin
                    x <= '0;
                    y <= '0;
                end else if (line_end) begin
                    x <= '0;
                    y <= y + 10'd1;
                end else begin
                    x <= x + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a shrunk raster so whole frames fit in a short
// run. Each step drives inputs, pushes the expected post-edge outputs from a
// reference model onto a queue, and pops/compares them after the clock edge.
module tb_vga_scanout;

    localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VA = 10, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;   // 25
    localparam int VT = VA + VFP + VSW + VBP;   // 15

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        ft;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [11:0] rgb_in;
    logic [10:0] x;
    logic [9:0]  y;
    logic        video_on;
    logic [11:0] vga_rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_tick;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
        .x(x), .y(y), .video_on(video_on), .vga_rgb(vga_rgb),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    // Reference model state (what the DUT registers should hold).
    int          mx, my;
    logic [11:0] mrgb;
    logic        mhs, mvs, mft;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_lo, vs_lo, ft_cnt, ft_at, nstep;

    task automatic step(input logic rst, input logic en, input logic [11:0] rgb);
        obs_t e, o;
        logic von;
        rst_n  = rst;
        pix_en = en;
        rgb_in = rgb;
        von = (mx < HA) && (my < VA);
        checks++;
        assert (video_on === von) else begin
            errors++;
            $error("FAIL video_on x=%0d y=%0d: got %b want %b", mx, my, video_on, von);
        end
        if (!rst) begin
            mx = 0; my = 0; mrgb = '0; mhs = 1'b1; mvs = 1'b1; mft = 1'b0;
        end else if (en) begin
            mrgb = von ? rgb : 12'h000;
            mhs  = !((mx >= HA + HFP) && (mx < HA + HFP + HSW));
            mvs  = !((my >= VA + VFP) && (my < VA + VFP + VSW));
            mft  = (mx == HT - 1) && (my == VA - 1);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end else begin
            mft = 1'b0;
        end
        q.push_back({11'(mx), 10'(my), mrgb, mhs, mvs, mft});
        @(posedge clk);
        #1;
        o = {x, y, vga_rgb, hsync, vsync, frame_tick};
        e = q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL step%0d x/y/rgb/hs/vs/ft: got %0d/%0d/%h/%b/%b/%b want %0d/%0d/%h/%b/%b/%b",
                   nstep, o.x, o.y, o.rgb, o.hs, o.vs, o.ft, e.x, e.y, e.rgb, e.hs, e.vs, e.ft);
        end
        if (!o.hs) hs_lo++;
        if (!o.vs) vs_lo++;
        if (o.ft) begin
            ft_cnt++;
            ft_at = nstep;
        end
        nstep++;
    endtask

    task automatic clear_stats();
        hs_lo = 0; vs_lo = 0; ft_cnt = 0; ft_at = -1; nstep = 0;
    endtask

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; rgb_in = '0;
        mx = 0; my = 0; mrgb = '0; mhs = 1'b1; mvs = 1'b1; mft = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;

        // Reset with pix_en high: enable must be ignored.
        step(1'b0, 1'b1, 12'hFFF);
        step(1'b0, 1'b1, 12'h123);

        // Line 0 only: hsync low for exactly HSW enables.
        clear_stats();
        for (int i = 0; i < HT; i++) step(1'b1, 1'b1, 12'hABC);
        checks++;
        assert (hs_lo === HSW) else begin
            errors++;
            $error("FAIL hsync_width line0: got %0d want %0d", hs_lo, HSW);
        end

        // Rest of the frame with constant colour; frame returns to (0,0).
        for (int i = HT; i < HT * VT; i++) step(1'b1, 1'b1, 12'hABC);
        checks++;
        assert (x === 11'd0 && y === 10'd0) else begin
            errors++;
            $error("FAIL frame_wrap: got x=%0d y=%0d want 0/0", x, y);
        end
        checks++;
        assert (vs_lo === VSW * HT) else begin
            errors++;
            $error("FAIL vsync_low_clocks: got %0d want %0d", vs_lo, VSW * HT);
        end
        checks++;
        assert (ft_cnt === 1 && ft_at === VA * HT - 1) else begin
            errors++;
            $error("FAIL frame_tick_once: got cnt=%0d at=%0d want 1 at %0d", ft_cnt, ft_at, VA * HT - 1);
        end

        // 1-of-4 enable with random colour; 400 enables cross one tick point.
        clear_stats();
        for (int i = 0; i < 1600; i++)
            step(1'b1, (i % 4) == 0, 12'($urandom_range(0, 4095)));
        checks++;
        assert (ft_cnt === 1) else begin
            errors++;
            $error("FAIL frame_tick_slow_en: got %0d want 1", ft_cnt);
        end

        // Advance to (7,5), reset for one clk, then resume counting.
        for (int i = 0; i < HT * VT && !(mx == 7 && my == 5); i++)
            step(1'b1, 1'b1, 12'h5A5);
        checks++;
        assert (x === 11'd7 && y === 10'd5) else begin
            errors++;
            $error("FAIL reach_midframe: got x=%0d y=%0d want 7/5", x, y);
        end
        step(1'b0, 1'b1, 12'h5A5);
        step(1'b1, 1'b1, 12'h321);
        step(1'b1, 1'b0, 12'h777);
        step(1'b1, 1'b1, 12'h456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
